// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result sink: controller state encoding and
// the bit-reversal mapping used to restore natural frequency-bin order.
package fft_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } fft_state_e;

   // Reverses the low n bits of k; bits at and above n come back as zero.
   function automatic logic [7:0] bitrev(input logic [7:0] k, input int n);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) r[i] = k[n - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_sink_buf.sv
// Frame buffer for the FFT sink: PNT x 32 register array with one write port
// and one registered read port whose output holds until the next read.
module fft_sink_buf
   import fft_pkg::*;
#(
   parameter int PNT = 16,
   parameter int N   = $clog2(PNT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [N-1:0]  waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [N-1:0]  raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [PNT];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // Contents are don't-care after reset, so the array itself has no reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_out_sink.sv
// Receives one FFT output frame over s_vld/s_rdy, stores it (bit-reversal
// undone when BITREV=1) and replays it in natural bin order over m_vld/m_rdy.
module fft_out_sink
   import fft_pkg::*;
#(
   parameter int PNT    = 16,
   parameter int N      = $clog2(PNT),
   parameter int BITREV = 1,
   parameter int FCW    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_vld,
   output logic           s_rdy,
   input  logic [31:0]    s_data,
   output logic           m_vld,
   input  logic           m_rdy,
   output logic [31:0]    m_data,
   output logic [N-1:0]   m_idx,
   output logic           m_last,
   output logic [FCW-1:0] frame_cnt,
   output logic           busy
);

   // Handshake rule on both sides: a word moves on a rising edge where vld
   // and rdy are both high; vld/data hold while rdy is low, and neither
   // ready nor valid is a combinational function of the opposite signal.

   localparam logic [N-1:0] LAST_IDX = N'(PNT - 1);

   fft_state_e     state_q, state_d;
   logic [N-1:0]   wcnt_q, wcnt_d;
   logic [N-1:0]   rcnt_q, rcnt_d;
   logic           s_rdy_q, s_rdy_d;
   logic           m_vld_q, m_vld_d;
   logic [N-1:0]   m_idx_q, m_idx_d;
   logic           m_last_q, m_last_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic           busy_q, busy_d;

   logic           buf_we;
   logic           buf_re;
   logic [N-1:0]   buf_waddr;
   logic [N-1:0]   buf_raddr;
   logic [N-1:0]   rcnt_nxt;

   assign rcnt_nxt  = rcnt_q + N'(1);
   assign buf_waddr = (BITREV != 0) ? N'(bitrev(8'(wcnt_q), N)) : wcnt_q;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      s_rdy_d     = s_rdy_q;
      m_vld_d     = m_vld_q;
      m_idx_d     = m_idx_q;
      m_last_d    = m_last_q;
      frame_cnt_d = frame_cnt_q;
      buf_we      = 1'b0;
      buf_re      = 1'b0;
      buf_raddr   = '0;
      unique case (state_q)
         FILL: begin
            s_rdy_d = 1'b1;
            m_vld_d = 1'b0;
            if (s_vld && s_rdy_q) begin
               buf_we = 1'b1;
               if (wcnt_q == LAST_IDX) begin
                  wcnt_d  = '0;
                  s_rdy_d = 1'b0;
                  state_d = LOAD;
               end else begin
                  wcnt_d = wcnt_q + N'(1);
               end
            end
         end
         LOAD: begin
            s_rdy_d   = 1'b0;
            buf_re    = 1'b1;
            buf_raddr = '0;
            m_idx_d   = '0;
            m_last_d  = (PNT == 1);
            m_vld_d   = 1'b1;
            state_d   = DRAIN;
         end
         DRAIN: begin
            s_rdy_d = 1'b0;
            if (m_vld_q && m_rdy) begin
               if (m_last_q) begin
                  m_vld_d     = 1'b0;
                  m_last_d    = 1'b0;
                  rcnt_d      = '0;
                  frame_cnt_d = frame_cnt_q + FCW'(1);
                  s_rdy_d     = 1'b1;
                  state_d     = FILL;
               end else begin
                  rcnt_d    = rcnt_nxt;
                  buf_re    = 1'b1;
                  buf_raddr = rcnt_nxt;
                  m_idx_d   = rcnt_nxt;
                  m_last_d  = (rcnt_nxt == LAST_IDX);
               end
            end
         end
         default: state_d = FILL;
      endcase
      // Computed from next-state values so busy stays a plain flop output.
      busy_d = (state_d != FILL) || (wcnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         s_rdy_q     <= 1'b0;
         m_vld_q     <= 1'b0;
         m_idx_q     <= '0;
         m_last_q    <= 1'b0;
         frame_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         s_rdy_q     <= s_rdy_d;
         m_vld_q     <= m_vld_d;
         m_idx_q     <= m_idx_d;
         m_last_q    <= m_last_d;
         frame_cnt_q <= frame_cnt_d;
         busy_q      <= busy_d;
      end
   end

   fft_sink_buf #(.PNT(PNT), .N(N)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (s_data),
      .re    (buf_re),
      .raddr (buf_raddr),
      .rdata (m_data)
   );

   assign s_rdy     = s_rdy_q;
   assign m_vld     = m_vld_q;
   assign m_idx     = m_idx_q;
   assign m_last    = m_last_q;
   assign frame_cnt = frame_cnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fft_out_sink.sv
// Directed bench for fft_out_sink: three instances share one stimulus stream
// (BITREV=1, BITREV=0, and BITREV=1 with a 2-bit frame counter).
module tb_fft_out_sink;

   logic        clk;
   logic        rst;
   logic        s_vld;
   logic [31:0] s_data;
   logic        m_rdy;

   logic        a_s_rdy, a_m_vld, a_m_last, a_busy;
   logic [31:0] a_m_data;
   logic [3:0]  a_m_idx;
   logic [15:0] a_frame_cnt;

   logic        b_s_rdy, b_m_vld, b_m_last, b_busy;
   logic [31:0] b_m_data;
   logic [3:0]  b_m_idx;
   logic [15:0] b_frame_cnt;

   logic        c_s_rdy, c_m_vld, c_m_last, c_busy;
   logic [31:0] c_m_data;
   logic [3:0]  c_m_idx;
   logic [1:0]  c_frame_cnt;

   int checks;
   int failures;
   int exp_frames;

   // Natural bin j holds input word bitrev4(j).
   logic [31:0] br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fft_out_sink #(.PNT(16), .BITREV(1), .FCW(16)) dut_a (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(a_s_rdy), .s_data(s_data),
      .m_vld(a_m_vld), .m_rdy(m_rdy), .m_data(a_m_data), .m_idx(a_m_idx),
      .m_last(a_m_last), .frame_cnt(a_frame_cnt), .busy(a_busy)
   );

   fft_out_sink #(.PNT(16), .BITREV(0), .FCW(16)) dut_b (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(b_s_rdy), .s_data(s_data),
      .m_vld(b_m_vld), .m_rdy(m_rdy), .m_data(b_m_data), .m_idx(b_m_idx),
      .m_last(b_m_last), .frame_cnt(b_frame_cnt), .busy(b_busy)
   );

   fft_out_sink #(.PNT(16), .BITREV(1), .FCW(2)) dut_c (
      .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(c_s_rdy), .s_data(s_data),
      .m_vld(c_m_vld), .m_rdy(m_rdy), .m_data(c_m_data), .m_idx(c_m_idx),
      .m_last(c_m_last), .frame_cnt(c_frame_cnt), .busy(c_busy)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      s_vld = 1'b0;
      m_rdy = 1'b0;
      s_data = '0;
      step();
      step();
      rst = 1'b0;
      exp_frames = 0;
   endtask

   // Driver: offers count words base+k; s_vld optionally left high afterwards.
   task automatic send_words(input logic [31:0] base, input int count, input bit hold);
      int  k;
      int  guard;
      logic acc;
      k = 0;
      guard = 0;
      s_vld  = 1'b1;
      s_data = base;
      while (k < count && guard < 100) begin
         acc = a_s_rdy;
         step();
         guard++;
         if (acc) k++;
         s_data = base + 32'(k);
      end
      if (!hold) s_vld = 1'b0;
      checks++;
      if (k != count) begin
         failures++;
         $display("FAIL send_accept: got %0d words, required %0d", k, count);
      end
      if (count == 16) begin
         checks++;
         if (a_s_rdy !== 1'b0 || a_m_vld !== 1'b0) begin
            failures++;
            $display("FAIL after_fill: s_rdy=%b m_vld=%b, required 0 0", a_s_rdy, a_m_vld);
         end
         step();
         checks++;
         if (a_m_vld !== 1'b1 || a_m_idx !== 4'd0 || b_m_vld !== 1'b1) begin
            failures++;
            $display("FAIL first_m_vld: a_vld=%b idx=%0d b_vld=%b, required 1 0 1",
                     a_m_vld, a_m_idx, b_m_vld);
         end
      end else begin
         checks++;
         if (a_busy !== 1'b1 || a_s_rdy !== 1'b1) begin
            failures++;
            $display("FAIL partial_busy: busy=%b s_rdy=%b, required 1 1", a_busy, a_s_rdy);
         end
      end
   endtask

   // Consumer + scoreboard for one drained frame; stalls when stall=1.
   task automatic drain_frame(input logic [31:0] base, input bit stall);
      int   i;
      int   guard;
      logic r;
      i = 0;
      guard = 0;
      while (i < 16 && guard < 400) begin
         guard++;
         checks++;
         if (a_m_vld !== 1'b1) begin
            failures++;
            $display("FAIL drain_vld: m_vld=%b at word %0d, required 1", a_m_vld, i);
         end
         checks++;
         if (a_m_data !== base + br_tab[i] || a_m_idx !== 4'(i) || a_m_last !== 1'(i == 15)) begin
            failures++;
            $display("FAIL bitrev_word: data=%0h idx=%0d last=%b, required %0h %0d %b",
                     a_m_data, a_m_idx, a_m_last, base + br_tab[i], i, 1'(i == 15));
         end
         checks++;
         if (b_m_data !== base + 32'(i) || b_m_idx !== 4'(i) || b_m_last !== 1'(i == 15)) begin
            failures++;
            $display("FAIL natural_word: data=%0h idx=%0d last=%b, required %0h %0d %b",
                     b_m_data, b_m_idx, b_m_last, base + 32'(i), i, 1'(i == 15));
         end
         checks++;
         if (c_m_data !== base + br_tab[i] || c_m_vld !== 1'b1) begin
            failures++;
            $display("FAIL fcw2_word: data=%0h vld=%b, required %0h 1", c_m_data, c_m_vld, base + br_tab[i]);
         end
         checks++;
         if (a_s_rdy !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_backpressure: s_rdy=%b busy=%b, required 0 1", a_s_rdy, a_busy);
         end
         r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         m_rdy = r;
         step();
         if (r) i++;
      end
      m_rdy = 1'b0;
      exp_frames++;
      checks++;
      if (i != 16) begin
         failures++;
         $display("FAIL drain_count: got %0d words, required 16", i);
      end
      checks++;
      if (a_m_vld !== 1'b0 || a_s_rdy !== 1'b1 || a_busy !== 1'b0 || a_m_last !== 1'b0) begin
         failures++;
         $display("FAIL frame_end: vld=%b s_rdy=%b busy=%b last=%b, required 0 1 0 0",
                  a_m_vld, a_s_rdy, a_busy, a_m_last);
      end
      checks++;
      if (a_frame_cnt !== 16'(exp_frames) || b_frame_cnt !== 16'(exp_frames) ||
          c_frame_cnt !== 2'(exp_frames)) begin
         failures++;
         $display("FAIL frame_cnt: a=%0d b=%0d c=%0d, required %0d (c mod 4)",
                  a_frame_cnt, b_frame_cnt, c_frame_cnt, exp_frames);
      end
      checks++;
      if (b_s_rdy !== 1'b1 || c_s_rdy !== 1'b1 || b_busy !== 1'b0 || c_busy !== 1'b0 ||
          b_m_vld !== 1'b0 || c_m_last !== 1'b0 || c_m_idx !== 4'd15) begin
         failures++;
         $display("FAIL frame_end_bc: b_s_rdy=%b c_s_rdy=%b b_busy=%b c_busy=%b b_vld=%b c_last=%b c_idx=%0d",
                  b_s_rdy, c_s_rdy, b_busy, c_busy, b_m_vld, c_m_last, c_m_idx);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (a_s_rdy !== 1'b0 || a_m_vld !== 1'b0 || a_m_data !== 32'd0 || a_m_idx !== 4'd0 ||
          a_m_last !== 1'b0 || a_frame_cnt !== 16'd0 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: s_rdy=%b m_vld=%b data=%0h idx=%0d last=%b fc=%0d busy=%b, required all 0",
                  a_s_rdy, a_m_vld, a_m_data, a_m_idx, a_m_last, a_frame_cnt, a_busy);
      end
      step();
      checks++;
      if (a_s_rdy !== 1'b1 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL s_rdy_rise: s_rdy=%b busy=%b, required 1 0", a_s_rdy, a_busy);
      end
   endtask

   task automatic test_bitrev_frame();
      send_words(32'd0, 16, 1'b0);
      drain_frame(32'd0, 1'b0);
   endtask

   task automatic test_stall_drain();
      send_words(32'h20, 16, 1'b0);
      drain_frame(32'h20, 1'b1);
   endtask

   task automatic test_svld_held();
      do_reset();
      for (int f = 0; f < 3; f++) begin
         send_words(32'(f * 16), 16, 1'b1);
         drain_frame(32'(f * 16), 1'b0);
      end
      s_vld = 1'b0;
      checks++;
      if (a_frame_cnt !== 16'd3) begin
         failures++;
         $display("FAIL held_frames: frame_cnt=%0d, required 3", a_frame_cnt);
      end
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      send_words(32'h55, 7, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_frames = 0;
      checks++;
      if (a_s_rdy !== 1'b0 || a_busy !== 1'b0 || a_m_vld !== 1'b0 || a_frame_cnt !== 16'd0) begin
         failures++;
         $display("FAIL mid_reset: s_rdy=%b busy=%b m_vld=%b fc=%0d, required 0 0 0 0",
                  a_s_rdy, a_busy, a_m_vld, a_frame_cnt);
      end
      send_words(32'h100, 16, 1'b0);
      drain_frame(32'h100, 1'b0);
   endtask

   task automatic test_fcw_wrap();
      logic [1:0] fc_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send_words(32'(32'h200 + f * 16), 16, 1'b0);
         drain_frame(32'(32'h200 + f * 16), 1'b1);
         checks++;
         if (c_frame_cnt !== fc_tab[f]) begin
            failures++;
            $display("FAIL fcw2_wrap: frame %0d frame_cnt=%0d, required %0d", f, c_frame_cnt, fc_tab[f]);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_frames = 0;
      rst = 1'b1;
      s_vld = 1'b0;
      s_data = '0;
      m_rdy = 1'b0;
      test_reset();
      test_bitrev_frame();
      test_stall_drain();
      test_svld_held();
      test_reset_mid_fill();
      test_fcw_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
